// File: rtl/quad_enc_pkg.sv
// Shared constants, FSM/step types and the quadrature step decoder for the
// encoder tracker.
package quad_enc_pkg;

    localparam logic [1:0] ST_00 = 2'b00;
    localparam logic [1:0] ST_01 = 2'b01;
    localparam logic [1:0] ST_11 = 2'b11;
    localparam logic [1:0] ST_10 = 2'b10;

    localparam logic DIR_CW  = 1'b1;
    localparam logic DIR_CCW = 1'b0;

    typedef enum logic {
        INIT  = 1'b0,
        TRACK = 1'b1
    } fsm_t;

    typedef enum logic [1:0] {
        STEP_NONE = 2'b00,
        STEP_CW   = 2'b01,
        STEP_CCW  = 2'b10,
        STEP_ILL  = 2'b11
    } step_t;

    // States are {a,b}; CW runs 00 -> 01 -> 11 -> 10 -> 00.
    function automatic step_t step_decode(input logic [1:0] prev_st, input logic [1:0] next_st);
        step_t res;
        if (prev_st == next_st) begin
            res = STEP_NONE;
        end else if ((prev_st ^ next_st) == 2'b11) begin
            res = STEP_ILL;
        end else begin
            case (prev_st)
                ST_00:   res = (next_st == ST_01) ? STEP_CW : STEP_CCW;
                ST_01:   res = (next_st == ST_11) ? STEP_CW : STEP_CCW;
                ST_11:   res = (next_st == ST_10) ? STEP_CW : STEP_CCW;
                ST_10:   res = (next_st == ST_00) ? STEP_CW : STEP_CCW;
                default: res = STEP_ILL;
            endcase
        end
        return res;
    endfunction

endpackage

// File: rtl/quad_enc_channel.sv
// One encoder channel: pin synchronisers, debouncers, INIT/TRACK FSM,
// step decoder and wrapping position counter.
module quad_enc_channel
    import quad_enc_pkg::*;
#(
    parameter int DEB_CYCLES = 80,
    parameter int POS_W      = 16,
    parameter int COUNT_X4   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    input  logic             clr,
    output logic [POS_W-1:0] pos,
    output logic             cw,
    output logic             ccw,
    output logic             dir,
    output logic             err
);

    localparam int               CNT_W    = $clog2(DEB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);

    logic [1:0]       sync1_r;
    logic [1:0]       sync2_r;
    logic [1:0]       filt_r;
    logic [1:0]       filt_nxt_s;
    logic [CNT_W-1:0] deb_cnt_r     [2];
    logic [CNT_W-1:0] deb_cnt_nxt_s [2];
    logic [CNT_W-1:0] stb_cnt_r;
    fsm_t             state_r;
    step_t            step_s;
    logic             up_s;
    logic             dn_s;
    logic             ill_s;

    // Per-pin debounce; bit 1 is A and bit 0 is B so filt_r reads as {a,b}
    always_comb begin
        filt_nxt_s = filt_r;
        for (int i = 0; i < 2; i++) begin
            deb_cnt_nxt_s[i] = '0;
            if (sync2_r[i] != filt_r[i]) begin
                if (deb_cnt_r[i] == CNT_LAST) begin
                    filt_nxt_s[i]    = sync2_r[i];
                    deb_cnt_nxt_s[i] = '0;
                end else begin
                    deb_cnt_nxt_s[i] = deb_cnt_r[i] + CNT_ONE;
                end
            end else begin
                deb_cnt_nxt_s[i] = '0;
            end
        end
    end

    // Decode filtered-state changes; x1 keeps only the steps landing on the 00 detent
    always_comb begin
        up_s  = 1'b0;
        dn_s  = 1'b0;
        ill_s = 1'b0;
        if (state_r == TRACK) begin
            step_s = step_decode(filt_r, filt_nxt_s);
        end else begin
            step_s = STEP_NONE;
        end
        case (step_s)
            STEP_CW:  up_s  = (COUNT_X4 != 32'sd0) || (filt_nxt_s == ST_00);
            STEP_CCW: dn_s  = (COUNT_X4 != 32'sd0) || (filt_nxt_s == ST_00);
            STEP_ILL: ill_s = 1'b1;
            default:  ill_s = 1'b0;
        endcase
    end

    // Synchronisers, debounce state and INIT/TRACK sequencing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r      <= 2'b00;
            sync2_r      <= 2'b00;
            filt_r       <= 2'b00;
            deb_cnt_r[0] <= '0;
            deb_cnt_r[1] <= '0;
            stb_cnt_r    <= '0;
            state_r      <= INIT;
        end else begin
            sync1_r      <= {a, b};
            sync2_r      <= sync1_r;
            filt_r       <= filt_nxt_s;
            deb_cnt_r[0] <= deb_cnt_nxt_s[0];
            deb_cnt_r[1] <= deb_cnt_nxt_s[1];
            if (state_r == INIT) begin
                if (sync2_r != filt_r) begin
                    stb_cnt_r <= '0;
                end else if (stb_cnt_r == CNT_LAST) begin
                    stb_cnt_r <= '0;
                    state_r   <= TRACK;
                end else begin
                    stb_cnt_r <= stb_cnt_r + CNT_ONE;
                end
            end else begin
                stb_cnt_r <= '0;
            end
        end
    end

    // Registered outputs; clear wins over a same-cycle step but its pulse still fires
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos <= '0;
            cw  <= 1'b0;
            ccw <= 1'b0;
            dir <= DIR_CCW;
            err <= 1'b0;
        end else begin
            cw  <= up_s;
            ccw <= dn_s;
            if (up_s) begin
                dir <= DIR_CW;
            end else if (dn_s) begin
                dir <= DIR_CCW;
            end else begin
                dir <= dir;
            end
            if (clr) begin
                pos <= '0;
                err <= 1'b0;
            end else begin
                if (up_s) begin
                    pos <= pos + POS_ONE;
                end else if (dn_s) begin
                    pos <= pos - POS_ONE;
                end else begin
                    pos <= pos;
                end
                err <= err | ill_s;
            end
        end
    end

endmodule

// File: rtl/quad_enc_tracker.sv
// Multi-channel quadrature encoder tracker: one independent channel per
// A/B pin pair, positions flattened channel-major onto pos.
module quad_enc_tracker #(
    parameter int CHANNELS   = 2,
    parameter int DEB_CYCLES = 80,
    parameter int POS_W      = 16,
    parameter int COUNT_X4   = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       a,
    input  logic [CHANNELS-1:0]       b,
    input  logic [CHANNELS-1:0]       clr,
    output logic [CHANNELS*POS_W-1:0] pos,
    output logic [CHANNELS-1:0]       cw,
    output logic [CHANNELS-1:0]       ccw,
    output logic [CHANNELS-1:0]       dir,
    output logic [CHANNELS-1:0]       err
);

    for (genvar i = 0; i < CHANNELS; i++) begin : gen_ch
        quad_enc_channel #(
            .DEB_CYCLES (DEB_CYCLES),
            .POS_W      (POS_W),
            .COUNT_X4   (COUNT_X4)
        ) u_ch (
            .clk (clk),
            .rst (rst),
            .a   (a[i]),
            .b   (b[i]),
            .clr (clr[i]),
            .pos (pos[i*POS_W +: POS_W]),
            .cw  (cw[i]),
            .ccw (ccw[i]),
            .dir (dir[i]),
            .err (err[i])
        );
    end

endmodule

// File: tb/tb_quad_enc_tracker.sv
// Bench for quad_enc_tracker: an x4 and an x1 instance share pins; a
// behavioural model built from sample histories and rotation phases checks both.
module tb_quad_enc_tracker;

    localparam int CH  = 2;
    localparam int DEB = 4;
    localparam int PW4 = 4;
    localparam int PW1 = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [CH-1:0] a, b, clr;
    logic [CH*PW4-1:0] pos4;
    logic [CH*PW1-1:0] pos1;
    logic [CH-1:0] cw4, ccw4, dir4, err4, cw1, ccw1, dir1, err1;

    int checks = 0;
    int errors = 0;

    // model state: raw sample histories (bit k = sample k edges ago), filtered levels, mode
    logic [DEB+1:0] ha [CH];
    logic [DEB+1:0] hb [CH];
    logic [DEB-1:0] sh [CH];
    logic fa [CH], fb [CH], trk [CH];
    int mpos [2][CH];
    bit mcw [2][CH], mccw [2][CH], mdir [2][CH], merr [2][CH];
    int n_cw4 [CH], n_ccw4 [CH], n_cw1 [CH], n_ccw1 [CH];

    always #5 clk = ~clk;

    quad_enc_tracker #(.CHANNELS(CH), .DEB_CYCLES(DEB), .POS_W(PW4), .COUNT_X4(1)) dut4 (
        .clk(clk), .rst(rst), .a(a), .b(b), .clr(clr),
        .pos(pos4), .cw(cw4), .ccw(ccw4), .dir(dir4), .err(err4));

    quad_enc_tracker #(.CHANNELS(CH), .DEB_CYCLES(DEB), .POS_W(PW1), .COUNT_X4(0)) dut1 (
        .clk(clk), .rst(rst), .a(a), .b(b), .clr(clr),
        .pos(pos1), .cw(cw1), .ccw(ccw1), .dir(dir1), .err(err1));

    function automatic int phase(input logic [1:0] st);
        case (st)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic int sx(input int v, input int w);
        int r;
        r = v & ((1 << w) - 1);
        if (r >= (1 << (w - 1))) r = r - (1 << w);
        return r;
    endfunction

    function automatic int p4(input int c);
        return int'($signed(pos4[c*PW4 +: PW4]));
    endfunction

    function automatic int p1(input int c);
        return int'($signed(pos1[c*PW1 +: PW1]));
    endfunction

    task automatic chk(input string nm, input int c, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s ch%0d: got %0d expected %0d at %0t", nm, c, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            ha[c] = '0; hb[c] = '0; sh[c] = '0;
            fa[c] = 1'b0; fb[c] = 1'b0; trk[c] = 1'b0;
            for (int m = 0; m < 2; m++) begin
                mpos[m][c] = 0; mcw[m][c] = 1'b0; mccw[m][c] = 1'b0;
                mdir[m][c] = 1'b0; merr[m][c] = 1'b0;
            end
        end
    endtask

    task automatic model_step();
        logic [1:0] o_st, n_st;
        logic stable;
        int d;
        for (int c = 0; c < CH; c++) begin
            ha[c] = {ha[c][DEB:0], a[c]};
            hb[c] = {hb[c][DEB:0], b[c]};
            o_st = {fa[c], fb[c]};
            stable = (ha[c][2] == fa[c]) && (hb[c][2] == fb[c]);
            if (ha[c][DEB+1:2] == {DEB{~fa[c]}}) fa[c] = ~fa[c];
            if (hb[c][DEB+1:2] == {DEB{~fb[c]}}) fb[c] = ~fb[c];
            n_st = {fa[c], fb[c]};
            for (int m = 0; m < 2; m++) begin
                mcw[m][c] = 1'b0; mccw[m][c] = 1'b0;
            end
            if (trk[c]) begin
                if (n_st != o_st) begin
                    d = (phase(n_st) - phase(o_st) + 4) % 4;
                    for (int m = 0; m < 2; m++) begin
                        if (d == 2) begin
                            merr[m][c] = 1'b1;
                        end else if (m == 0 || n_st == 2'b00) begin
                            if (d == 1) begin
                                mcw[m][c] = 1'b1; mpos[m][c]++; mdir[m][c] = 1'b1;
                            end else begin
                                mccw[m][c] = 1'b1; mpos[m][c]--; mdir[m][c] = 1'b0;
                            end
                        end
                    end
                end
            end else begin
                sh[c] = {sh[c][DEB-2:0], stable};
                if (&sh[c]) trk[c] = 1'b1;
            end
            if (clr[c]) begin
                for (int m = 0; m < 2; m++) begin
                    mpos[m][c] = 0; merr[m][c] = 1'b0;
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int c = 0; c < CH; c++) begin
            chk("pos_x4", c, p4(c), sx(mpos[0][c], PW4));
            chk("cw_x4",  c, int'(cw4[c]),  int'(mcw[0][c]));
            chk("ccw_x4", c, int'(ccw4[c]), int'(mccw[0][c]));
            chk("dir_x4", c, int'(dir4[c]), int'(mdir[0][c]));
            chk("err_x4", c, int'(err4[c]), int'(merr[0][c]));
            chk("pos_x1", c, p1(c), sx(mpos[1][c], PW1));
            chk("cw_x1",  c, int'(cw1[c]),  int'(mcw[1][c]));
            chk("ccw_x1", c, int'(ccw1[c]), int'(mccw[1][c]));
            chk("dir_x1", c, int'(dir1[c]), int'(mdir[1][c]));
            chk("err_x1", c, int'(err1[c]), int'(merr[1][c]));
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            if (rst) model_reset(); else model_step();
            @(negedge clk);
            compare_all();
            for (int c = 0; c < CH; c++) begin
                n_cw4[c] += int'(cw4[c]); n_ccw4[c] += int'(ccw4[c]);
                n_cw1[c] += int'(cw1[c]); n_ccw1[c] += int'(ccw1[c]);
            end
        end
    endtask

    task automatic set_ch(input int c, input logic [1:0] st);
        a[c] = st[1];
        b[c] = st[0];
    endtask

    initial begin
        int b0, b1, b2, b3;
        logic [1:0] cw_seq [4];
        logic [1:0] ccw_seq [4];
        cw_seq  = '{2'b10, 2'b00, 2'b01, 2'b11};
        ccw_seq = '{2'b01, 2'b00, 2'b10, 2'b11};
        for (int c = 0; c < CH; c++) begin
            n_cw4[c] = 0; n_ccw4[c] = 0; n_cw1[c] = 0; n_ccw1[c] = 0;
        end
        a = 2'b11; b = 2'b11; clr = 2'b00;
        #1 rst = 1'b1;
        model_reset();
        tick(3);
        rst = 1'b0;
        tick(20);
        for (int c = 0; c < CH; c++) begin
            chk("init_pos", c, p4(c), 0);
            chk("init_err", c, int'(err4[c]) + int'(err1[c]), 0);
            chk("init_pulses", c, n_cw4[c] + n_ccw4[c] + n_cw1[c] + n_ccw1[c], 0);
        end

        // x4/x1: ch0 one CW cycle while ch1 runs one CCW cycle
        b0 = n_cw4[0]; b1 = n_ccw4[1];
        for (int k = 0; k < 4; k++) begin
            set_ch(0, cw_seq[k]); set_ch(1, ccw_seq[k]); tick(6);
        end
        tick(2);
        chk("x4_cw_pos", 0, p4(0), 4);
        chk("x4_cw_pulses", 0, n_cw4[0] - b0, 4);
        chk("x4_cw_dir", 0, int'(dir4[0]), 1);
        chk("x4_ccw_pos", 1, p4(1), -4);
        chk("x4_ccw_pulses", 1, n_ccw4[1] - b1, 4);
        chk("x1_cw_pos", 0, p1(0), 1);
        chk("x1_ccw_pos", 1, p1(1), -1);

        // reverse ch0
        for (int k = 0; k < 4; k++) begin set_ch(0, ccw_seq[k]); tick(6); end
        tick(2);
        chk("x4_rev_pos", 0, p4(0), 0);
        chk("x4_rev_dir", 0, int'(dir4[0]), 0);
        chk("x1_rev_pos", 0, p1(0), 0);

        // x1: two CW detents then one CCW detent
        b2 = n_cw1[0]; b3 = n_ccw1[0];
        for (int k = 0; k < 8; k++) begin set_ch(0, cw_seq[k % 4]); tick(6); end
        for (int k = 0; k < 4; k++) begin set_ch(0, ccw_seq[k]); tick(6); end
        tick(2);
        chk("x1_det_pos", 0, p1(0), 1);
        chk("x1_det_cw", 0, n_cw1[0] - b2, 2);
        chk("x1_det_ccw", 0, n_ccw1[0] - b3, 1);
        chk("x4_det_pos", 0, p4(0), 4);

        // debounce: 3-cycle glitch discarded, 4-cycle hold steps on edge 6
        set_ch(0, 2'b01); tick(3); set_ch(0, 2'b11); tick(6);
        chk("glitch_pos", 0, p4(0), 4);
        set_ch(0, 2'b01); tick(5);
        chk("deb_e5_pos", 0, p4(0), 4);
        chk("deb_e5_ccw", 0, int'(ccw4[0]), 0);
        tick(1);
        chk("deb_e6_pos", 0, p4(0), 3);
        chk("deb_e6_ccw", 0, int'(ccw4[0]), 1);
        tick(2);

        // illegal 01 -> 10
        set_ch(0, 2'b10); tick(8);
        chk("ill_err_x4", 0, int'(err4[0]), 1);
        chk("ill_err_x1", 0, int'(err1[0]), 1);
        chk("ill_pos", 0, p4(0), 3);

        // clear coinciding with a CW step 10 -> 00
        set_ch(0, 2'b00); tick(5);
        clr[0] = 1'b1; tick(1); clr[0] = 1'b0;
        chk("clr_pos_x4", 0, p4(0), 0);
        chk("clr_pos_x1", 0, p1(0), 0);
        chk("clr_err", 0, int'(err4[0]), 0);
        chk("clr_cw_x4", 0, int'(cw4[0]), 1);
        chk("clr_cw_x1", 0, int'(cw1[0]), 1);
        tick(2);

        // wrap: 7 CW steps to +7, one more to -8
        for (int k = 0; k < 7; k++) begin set_ch(0, cw_seq[(k + 2) % 4]); tick(6); end
        tick(2);
        chk("wrap_max", 0, p4(0), 7);
        set_ch(0, 2'b00); tick(8);
        chk("wrap_min", 0, p4(0), -8);

        // random stimulus, asynchronous mid-run reset, more random stimulus
        for (int ph = 0; ph < 2; ph++) begin
            repeat (1500) begin
                for (int c = 0; c < CH; c++) begin
                    if ($urandom_range(0, 5) == 0) a[c] = ~a[c];
                    if ($urandom_range(0, 5) == 0) b[c] = ~b[c];
                    clr[c] = ($urandom_range(0, 40) == 0);
                end
                tick(1);
            end
            if (ph == 0) begin
                #2 rst = 1'b1;
                model_reset();
                #1;
                chk("rst_pos", 0, int'(pos4) + int'(pos1), 0);
                chk("rst_pulses", 0, int'(cw4) + int'(ccw4) + int'(cw1) + int'(ccw1), 0);
                chk("rst_dir_err", 0, int'(dir4) + int'(err4) + int'(dir1) + int'(err1), 0);
                tick(2);
                rst = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
